// File: rtl/puf_challenge_scrambler.sv
// puf_challenge_scrambler
// Reads P_NUM_WORDS raw PUF words from a source region, XORs each with an
// 8-bit Galois LFSR keystream seeded by the challenge seed, and writes the
// result to a destination region. done_Scrambler is held once the last word
// has been written.
//
// Optional feature macro: PUF_SCR_BYPASS_EN
//   Adds input scr_bypass. When it is high in WRITE, the source word is
//   copied unmodified, but the LFSR still advances so later words keep
//   their keystream alignment.
//
// Handshake: src_rd_en is a one-cycle strobe with src_addr valid in the same
// cycle; src_rd_data is consumed in the following cycle (WRITE). dst_wr_en is
// a one-cycle strobe with dst_addr/dst_wr_data valid in the same cycle. There
// is no back-pressure on either side. The two strobes are never high together.
// Address, data and strobe outputs are 0 whenever no strobe is active.
// o_dbg_state exposes the FSM state for observation.
module puf_challenge_scrambler #(
    parameter int                      P_ADDR_WIDTH = 12,
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_NUM_WORDS  = 16,
    parameter logic [P_ADDR_WIDTH-1:0] P_SRC_BASE   = 12'h000,
    parameter logic [P_ADDR_WIDTH-1:0] P_DST_BASE   = 12'h100,
    parameter logic [7:0]              P_LFSR_POLY  = 8'hB8
) (
    input  logic                    clk,
    input  logic                    Resetn,
    input  logic                    En_Scrambler,
    input  logic                    Reset_Scrambler,
    input  logic [7:0]              Seed_Data_LFSR,
`ifdef PUF_SCR_BYPASS_EN
    input  logic                    scr_bypass,
`endif
    output logic                    done_Scrambler,
    output logic                    src_rd_en,
    output logic [P_ADDR_WIDTH-1:0] src_addr,
    input  logic [P_DATA_WIDTH-1:0] src_rd_data,
    output logic                    dst_wr_en,
    output logic [P_ADDR_WIDTH-1:0] dst_addr,
    output logic [P_DATA_WIDTH-1:0] dst_wr_data,
    output logic [2:0]              o_dbg_state
);

    localparam int K = P_DATA_WIDTH / 8;
    localparam logic [P_ADDR_WIDTH-1:0] LAST_IDX = P_ADDR_WIDTH'(P_NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_lfsr;
    logic [7:0]              w_lfsr_nxt;
    logic [7:0]              w_lfsr_adv;
    logic [P_ADDR_WIDTH-1:0] r_idx;
    logic [P_ADDR_WIDTH-1:0] w_idx_nxt;
    logic [P_DATA_WIDTH-1:0] w_keystream;
    logic [P_DATA_WIDTH-1:0] w_wr_data;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ P_LFSR_POLY) : (s >> 1);
    endfunction

    // Keystream word: K successive LFSR states, current state in the MSB byte;
    // the state after the last byte is the LFSR value for the next word.
    always_comb begin : keystream_gen
        logic [7:0] v_s;
        w_keystream = '0;
        v_s         = r_lfsr;
        for (int k = 0; k < K; k++) begin
            w_keystream[P_DATA_WIDTH-1-8*k -: 8] = v_s;
            v_s = lfsr_step(v_s);
        end
        w_lfsr_adv = v_s;
    end

    // Scrambled write data, optionally passed through unmodified.
    always_comb begin
`ifdef PUF_SCR_BYPASS_EN
        w_wr_data = scr_bypass ? src_rd_data : (src_rd_data ^ w_keystream);
`else
        w_wr_data = src_rd_data ^ w_keystream;
`endif
    end

    // Next-state and output decode; Reset_Scrambler overrides every state and
    // suppresses any strobe in the same cycle so an in-flight write is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_lfsr_nxt     = r_lfsr;
        w_idx_nxt      = r_idx;
        done_Scrambler = 1'b0;
        src_rd_en      = 1'b0;
        src_addr       = '0;
        dst_wr_en      = 1'b0;
        dst_addr       = '0;
        dst_wr_data    = '0;
        if (Reset_Scrambler) begin
            w_state_nxt = S_ARM;
            w_idx_nxt   = '0;
            w_lfsr_nxt  = (Seed_Data_LFSR == 8'h00) ? 8'h01 : Seed_Data_LFSR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_ARM: begin
                    if (En_Scrambler) w_state_nxt = S_READ;
                end
                S_READ: begin
                    if (En_Scrambler) begin
                        src_rd_en   = 1'b1;
                        src_addr    = P_SRC_BASE + r_idx;
                        w_state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    dst_wr_en   = 1'b1;
                    dst_addr    = P_DST_BASE + r_idx;
                    dst_wr_data = w_wr_data;
                    w_lfsr_nxt  = w_lfsr_adv;
                    w_idx_nxt   = r_idx + P_ADDR_WIDTH'(1);
                    w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_READ;
                end
                S_DONE: begin
                    done_Scrambler = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, LFSR and word index registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_lfsr  <= 8'h01;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_puf_challenge_scrambler.sv
// Directed bench for puf_challenge_scrambler (defaults: 32-bit words,
// 16 words, src base 0x000, dst base 0x100, poly B8).
module tb_puf_challenge_scrambler;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        En_Scrambler;
    logic        Reset_Scrambler;
    logic [7:0]  Seed_Data_LFSR;
`ifdef PUF_SCR_BYPASS_EN
    logic        scr_bypass;
`endif
    logic        done_Scrambler;
    logic        src_rd_en;
    logic [11:0] src_addr;
    logic [31:0] src_rd_data = '0;
    logic        dst_wr_en;
    logic [11:0] dst_addr;
    logic [31:0] dst_wr_data;
    logic [2:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rd_cnt, wr_cnt, overlap_cnt, first_rd_cyc, done_cyc;
    bit done_seen;

    logic [31:0] src_mem [0:4095];
    logic [31:0] dst_mem [0:4095];

    puf_challenge_scrambler dut (
        .clk            (clk),
        .Resetn         (Resetn),
        .En_Scrambler   (En_Scrambler),
        .Reset_Scrambler(Reset_Scrambler),
        .Seed_Data_LFSR (Seed_Data_LFSR),
`ifdef PUF_SCR_BYPASS_EN
        .scr_bypass     (scr_bypass),
`endif
        .done_Scrambler (done_Scrambler),
        .src_rd_en      (src_rd_en),
        .src_addr       (src_addr),
        .src_rd_data    (src_rd_data),
        .dst_wr_en      (dst_wr_en),
        .dst_addr       (dst_addr),
        .dst_wr_data    (dst_wr_data),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: registered read, data valid the cycle after the strobe
    always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_addr];

    // Mid-cycle monitor: strobe counts, destination capture, done timing
    always @(negedge clk) begin
        if (src_rd_en && dst_wr_en) overlap_cnt = overlap_cnt + 1;
        if (src_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (dst_wr_en) begin
            dst_mem[dst_addr] = dst_wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (done_Scrambler && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    // Reference keystream word n for a seed, XORed with the source word
    function automatic logic [31:0] exp_word(input logic [7:0] seed, input int n,
                                             input logic [31:0] src);
        logic [7:0]  l;
        logic [31:0] w;
        l = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < 4 * n; i++) l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
        for (int b = 0; b < 4; b++) begin
            w = {w[23:0], l};
            l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
        end
        return w ^ src;
    endfunction

    task automatic clear_mon();
        rd_cnt       = 0;
        wr_cnt       = 0;
        overlap_cnt  = 0;
        first_rd_cyc = -1;
        done_cyc     = -1;
        done_seen    = 1'b0;
        for (int i = 0; i < 16; i++) dst_mem[12'h100 + i] = 'x;
    endtask

    task automatic fill_src(input logic [31:0] base, input logic [31:0] inc);
        for (int i = 0; i < 16; i++) src_mem[i] = base + inc * i;
    endtask

    task automatic start_run(input logic [7:0] seed);
        @(posedge clk); #1;
        Seed_Data_LFSR  = seed;
        Reset_Scrambler = 1'b1;
        En_Scrambler    = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        Reset_Scrambler = 1'b0;
        Seed_Data_LFSR  = ~seed;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s_timeout: done_Scrambler=%0b required 1 within %0d cycles",
                     name, done_Scrambler, budget);
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        for (int i = 0; i < budget && wr_cnt < n; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (wr_cnt < n) begin
            errors++;
            $display("FAIL %s_write_timeout: writes=%0d required %0d", name, wr_cnt, n);
        end
    endtask

    task automatic check_words(input logic [7:0] seed, input string name);
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = exp_word(seed, i, src_mem[i]);
            checks++;
            if (dst_mem[12'h100 + i] !== exp) begin
                errors++;
                $display("FAIL %s_word%0d: got %h required %h", name, i,
                         dst_mem[12'h100 + i], exp);
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; En_Scrambler = 1'b0; Reset_Scrambler = 1'b0;
        Seed_Data_LFSR = 8'h00;
`ifdef PUF_SCR_BYPASS_EN
        scr_bypass = 1'b0;
`endif
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done_Scrambler, src_rd_en, dst_wr_en, src_addr, dst_addr, dst_wr_data} !== '0
            || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b rd=%b wr=%b sa=%h da=%h d=%h st=%0d required all 0",
                     done_Scrambler, src_rd_en, dst_wr_en, src_addr, dst_addr, dst_wr_data, o_dbg_state);
        end
        Resetn = 1'b1; En_Scrambler = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt !== 0 || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_en_only: reads=%0d state=%0d required 0 reads, state 0", rd_cnt, o_dbg_state);
        end
    endtask

    task automatic test_basic();
        int rd_at_done;
        fill_src(32'h0, 32'h0);
        start_run(8'h01);
        wait_done(100, "basic");
        checks++;
        if (dst_mem[12'h100] !== 32'h01B85C2E) begin
            errors++; $display("FAIL basic_w0: got %h required 01b85c2e", dst_mem[12'h100]);
        end
        checks++;
        if (dst_mem[12'h101] !== 32'h17B3E1C8) begin
            errors++; $display("FAIL basic_w1: got %h required 17b3e1c8", dst_mem[12'h101]);
        end
        checks++;
        if (done_cyc - first_rd_cyc !== 32) begin
            errors++; $display("FAIL basic_latency: got %0d required 32", done_cyc - first_rd_cyc);
        end
        checks++;
        if (wr_cnt !== 16 || overlap_cnt !== 0) begin
            errors++; $display("FAIL basic_counts: writes=%0d overlap=%0d required 16, 0", wr_cnt, overlap_cnt);
        end
        check_words(8'h01, "basic");
        rd_at_done = rd_cnt;
        En_Scrambler = 1'b0;
        repeat (3) @(posedge clk);
        En_Scrambler = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_Scrambler !== 1'b1 || rd_cnt !== rd_at_done || wr_cnt !== 16) begin
            errors++;
            $display("FAIL done_hold: done=%b reads=%0d writes=%0d required 1, %0d, 16",
                     done_Scrambler, rd_cnt, wr_cnt, rd_at_done);
        end
    endtask

    task automatic test_back_to_back();
        fill_src(32'h0F00_0000, 32'h0101_0101);
        start_run(8'hC3);
        wait_done(100, "b2b");
        checks++;
        if (wr_cnt !== 16 || done_cyc - first_rd_cyc !== 32) begin
            errors++;
            $display("FAIL b2b_counts: writes=%0d latency=%0d required 16, 32", wr_cnt, done_cyc - first_rd_cyc);
        end
        check_words(8'hC3, "b2b");
    endtask

    task automatic test_seed_zero();
        fill_src(32'h0, 32'h0);
        start_run(8'h00);
        wait_done(100, "seed0");
        checks++;
        if (dst_mem[12'h100] !== 32'h01B85C2E || dst_mem[12'h101] !== 32'h17B3E1C8) begin
            errors++;
            $display("FAIL seed0_guard: got %h %h required 01b85c2e 17b3e1c8",
                     dst_mem[12'h100], dst_mem[12'h101]);
        end
    endtask

    task automatic test_en_gap();
        fill_src(32'h0F00_0000, 32'h0101_0101);
        start_run(8'h01);
        wait_writes(1, 20, "gap");
        En_Scrambler = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 1) begin
            errors++; $display("FAIL gap_strobes: reads=%0d writes=%0d required 1, 1", rd_cnt, wr_cnt);
        end
        En_Scrambler = 1'b1;
        wait_done(100, "gap");
        checks++;
        if (done_cyc - first_rd_cyc !== 35) begin
            errors++; $display("FAIL gap_latency: got %0d required 35", done_cyc - first_rd_cyc);
        end
        check_words(8'h01, "gap");
    endtask

    task automatic test_midrun_reset();
        fill_src(32'h0, 32'h0);
        start_run(8'h01);
        wait_writes(6, 40, "mid");
        Reset_Scrambler = 1'b1;
        Seed_Data_LFSR  = 8'h5A;
        clear_mon();
        @(posedge clk); #1;
        Reset_Scrambler = 1'b0;
        Seed_Data_LFSR  = 8'h33;
        wait_done(100, "mid");
        checks++;
        if (dst_mem[12'h100] !== 32'h5A2DAE57) begin
            errors++; $display("FAIL mid_w0: got %h required 5a2dae57", dst_mem[12'h100]);
        end
        checks++;
        if (wr_cnt !== 16 || done_cyc - first_rd_cyc !== 32) begin
            errors++;
            $display("FAIL mid_counts: writes=%0d latency=%0d required 16, 32", wr_cnt, done_cyc - first_rd_cyc);
        end
        check_words(8'h5A, "mid");
    endtask

`ifdef PUF_SCR_BYPASS_EN
    task automatic test_bypass();
        fill_src(32'hDEADBEEF, 32'h0);
        scr_bypass = 1'b1;
        start_run(8'h01);
        wait_writes(1, 20, "byp");
        scr_bypass = 1'b0;
        wait_done(100, "byp");
        checks++;
        if (dst_mem[12'h100] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL byp_w0: got %h required deadbeef", dst_mem[12'h100]);
        end
        checks++;
        if (dst_mem[12'h101] !== (32'hDEADBEEF ^ 32'h17B3E1C8)) begin
            errors++; $display("FAIL byp_w1: got %h required %h", dst_mem[12'h101], 32'hDEADBEEF ^ 32'h17B3E1C8);
        end
    endtask
`endif

    task automatic test_resetn_in_write();
        bit seen_wr;
        fill_src(32'h1234_5678, 32'h1);
        start_run(8'h01);
        seen_wr = 1'b0;
        for (int i = 0; i < 10 && !seen_wr; i++) begin
            @(posedge clk); #1;
            seen_wr = dst_wr_en;
        end
        checks++;
        if (!seen_wr) begin
            errors++; $display("FAIL rstn_reach_write: dst_wr_en=%b required 1", dst_wr_en);
        end
        Resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done_Scrambler, src_rd_en, dst_wr_en, src_addr, dst_addr, dst_wr_data} !== '0
            || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL rstn_outputs: done=%b rd=%b wr=%b sa=%h da=%h d=%h st=%0d required all 0",
                     done_Scrambler, src_rd_en, dst_wr_en, src_addr, dst_addr, dst_wr_data, o_dbg_state);
        end
        Resetn = 1'b1;
        En_Scrambler = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL rstn_en_only: reads=%0d writes=%0d state=%0d required 0, 0, 0",
                     rd_cnt, wr_cnt, o_dbg_state);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            src_mem[i] = '0;
            dst_mem[i] = 'x;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_seed_zero();
        test_en_gap();
        test_midrun_reset();
`ifdef PUF_SCR_BYPASS_EN
        test_bypass();
`endif
        test_resetn_in_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_challenge_scrambler.md
Name: puf_challenge_scrambler

Overview:
- Scrambler stage driven directly by the PUF controller through En_Scrambler, Reset_Scrambler, Seed_Data_LFSR and done_Scrambler.
- Reads P_NUM_WORDS raw PUF words from a source memory and XORs each with an LFSR keystream seeded by the challenge seed.
- Writes the results to a destination memory region, where the ECC decoder stage picks them up.
- Raises done_Scrambler when the last word has been written.

Parameters:
P_ADDR_WIDTH, 12, memory address width
P_DATA_WIDTH, 32, memory word width; must be a multiple of 8
P_NUM_WORDS, 16, words scrambled per run; range 1 to 2^P_ADDR_WIDTH
P_SRC_BASE, 12'h000, source region base address
P_DST_BASE, 12'h100, destination region base address
P_LFSR_POLY, 8'hB8, Galois LFSR tap mask

Ports:
clk  in  1  clock, rising edge
Resetn  in  1  synchronous, active-low reset
En_Scrambler  in  1  enable; when low, no new read is issued
Reset_Scrambler  in  1  re-arm and load seed; highest priority after Resetn
Seed_Data_LFSR  in  8  challenge seed
done_Scrambler  out  1  run complete (level)
src_rd_en  out  1  source read strobe
src_addr  out  P_ADDR_WIDTH  source address
src_rd_data  in  P_DATA_WIDTH  source data, valid 1 cycle after src_rd_en
dst_wr_en  out  1  destination write strobe
dst_addr  out  P_ADDR_WIDTH  destination address
dst_wr_data  out  P_DATA_WIDTH  scrambled word

Behaviour:
- Reset and clock: single clock clk; reset Resetn is synchronous and active-low.
- Resetn low at a rising edge: state=IDLE, lfsr=8'h01, idx=0.
  - All outputs 0: done_Scrambler, src_rd_en, dst_wr_en, addresses, dst_wr_data.
- LFSR step: next = lfsr[0] ? (lfsr>>1)^P_LFSR_POLY : lfsr>>1.
- Keystream word: concatenation of K=P_DATA_WIDTH/8 successive states, current state in the MSB byte, e.g. {s0,s1,s2,s3}.
  - After each word, lfsr advances K steps.
- States: IDLE, ARM, READ, WRITE, DONE.
- Reset_Scrambler high at any edge, from any state including mid-run:
  - next state ARM; idx<=0.
  - lfsr<=Seed_Data_LFSR, except seed 8'h00 is replaced by 8'h01 (lockup guard).
  - done_Scrambler cleared.
  - A write in flight is dropped.
- IDLE: waits for Reset_Scrambler; En alone does nothing.
- ARM: Reset_Scrambler low and En high -> READ; otherwise stay.
- READ:
  - En low: stay, src_rd_en=0.
  - En high: src_rd_en=1 and src_addr=P_SRC_BASE+idx for exactly this cycle, then -> WRITE.
- WRITE: always completes regardless of En.
  - dst_wr_en=1, dst_addr=P_DST_BASE+idx, dst_wr_data=src_rd_data^keystream.
  - lfsr advances K steps; idx++.
  - If idx==P_NUM_WORDS-1 -> DONE, else -> READ.
- DONE: done_Scrambler=1 (held), strobes 0; leaves only on Reset_Scrambler or Resetn.
- Address arithmetic wraps modulo 2^P_ADDR_WIDTH.
- src_rd_en and dst_wr_en are never high in the same cycle.
- Latency with En held high: first src_rd_en appears 1 cycle after ARM is entered with Reset_Scrambler low. done_Scrambler rises 2*P_NUM_WORDS cycles after that first src_rd_en.
- Seed is sampled only while Reset_Scrambler is high; later changes are ignored.

Optional Feature:
- Macro PUF_SCR_BYPASS_EN.
- Defined:
  - Adds input port scr_bypass (1 bit), sampled in WRITE.
  - When scr_bypass is high, dst_wr_data=src_rd_data unmodified; the LFSR still advances, so the keystream alignment of later words is unchanged.
- Undefined: port absent; data is always scrambled.

Test Plan:
- Seed 8'h01, poly B8, P_NUM_WORDS=2, src words all 0, En high -> dst[0x100]=32'h01B85C2E, dst[0x101]=32'h17B3E1C8; done_Scrambler rises 4 cycles after first src_rd_en.
- Seed 8'h00, src=0 -> output identical to seed 8'h01 case (lockup guard).
- En dropped for 3 cycles while in READ after word 0 -> no strobes during the gap; final dst data identical to the uninterrupted run; done delayed by exactly 3 cycles.
- Reset_Scrambler pulsed mid-run after word 5 of 16 with seed 8'h5A -> idx restarts at 0; dst[0x100] rewritten with the 8'h5A keystream; done only after 16 further writes.
- Resetn low in WRITE -> dst_wr_en 0 at next edge; all outputs 0; IDLE; an En-only stimulus afterwards produces no reads.
- PUF_SCR_BYPASS_EN defined, scr_bypass high for word 0 only, src=32'hDEADBEEF -> dst[0x100]=32'hDEADBEEF, dst[0x101]=32'hDEADBEEF^32'h17B3E1C8.
